darkuart_txarb: RTL and testbench

Round-robin arbiter that shares the single SoC UART transmitter between `NREQ` byte producers, such as the two harts of a multithreaded core or a hart plus a hardware debug monitor. Each requester gets a small byte FIFO. The arbiter drains the FIFOs into the UART's byte-level valid/ready transmit port. An optional line lock keeps one requester's output line intact so that lines from different requesters never interleave. The block sits between the per-requester I/O registers and the UART TX shifter inside darksocv.

---
 rtl/darkuart_pkg.sv | 22 ++
 rtl/darkuart_fifo.sv | 54 +++++
 rtl/darkuart_txarb.sv | 134 +++++++++++++
 tb/tb_darkuart_txarb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/darkuart_pkg.sv
// Shared definitions for the darkuart transmit path: byte type, newline code,
// arbiter state encoding and a constant-evaluable ceil(log2) helper.
package darkuart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t UART_NL = 8'h0A;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Smallest width w with 2**w >= value; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/darkuart_fifo.sv
// Single-clock byte FIFO, one per requester. DEPTH must be a power of two so
// the pointers wrap naturally; dout shows the head entry whenever not empty.
module darkuart_fifo
  import darkuart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  byte_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array written at the tail.
  // NOTE: the array is not reset; clearing the count already discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/darkuart_txarb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Optional line lock (macro UARTARB_LINELOCK_EN) keeps one requester's line
// contiguous until it sends a newline or its FIFO idles for LOCK_TMO cycles.
module darkuart_txarb
  import darkuart_pkg::*;
#(
  parameter  int unsigned NREQ     = 2,
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned LOCK_TMO = 1024,
  localparam int unsigned OWN_W    = (clog2(NREQ) > 1) ? clog2(NREQ) : 1
) (
  input  logic                CLK,
  input  logic                RES_N,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [8*NREQ-1:0]   REQ_DATA,
  output logic [NREQ-1:0]     REQ_READY,
  output logic                TX_VALID,
  output logic [7:0]          TX_DATA,
  input  logic                TX_READY,
  output logic [OWN_W-1:0]    OWNER,
  output logic                LOCKED
);

  // Reject unsupported configurations at elaboration.
  if (NREQ < 2 || NREQ > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LOCK_TMO < 1)
  begin : g_bad_params
    $error("darkuart_txarb: unsupported parameter set");
  end

  byte_t            fifo_dout [NREQ];
  logic [NREQ-1:0]  fifo_full;
  logic [NREQ-1:0]  fifo_empty;
  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  pop;
  logic [NREQ-1:0]  eligible;
  arb_state_t       state;
  byte_t            tx_data;
  logic [OWN_W-1:0] owner;
  logic [OWN_W-1:0] grant_idx;
  logic             grant_hit;
  logic             load;
  logic             locked;

  assign REQ_READY = ~fifo_full;
  assign push      = REQ_VALID & ~fifo_full;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    darkuart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (RES_N),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (REQ_DATA[8*i +: 8]),
      .dout  (fifo_dout[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  // While locked only the owner may be granted; others simply queue up.
  assign eligible = locked ? (~fifo_empty & (NREQ'(1) << owner)) : ~fifo_empty;

  // Search OWNER+1, OWNER+2, ... (owner itself last) for the first eligible FIFO.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [OWN_W-1:0] cand;
    cand      = owner;
    grant_hit = 1'b0;
    grant_idx = owner;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OWN_W'((32'(owner) + k) % NREQ);
      if (!grant_hit && eligible[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Reload only when the output register is empty or being accepted this cycle.
  assign load = grant_hit & ((state == ST_IDLE) | TX_READY);

  // One-hot pop of the winning FIFO, same cycle as the output load.
  always_comb begin
    pop = '0;
    if (load) pop[grant_idx] = 1'b1;
  end

  // Output register FSM: IDLE has nothing pending, GRANT holds a byte for the UART.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state   <= ST_IDLE;
      tx_data <= '0;
      owner   <= OWN_W'(NREQ - 1);
    end else if (load) begin
      state   <= ST_GRANT;
      tx_data <= fifo_dout[grant_idx];
      owner   <= grant_idx;
    end else if (TX_READY) begin
      state   <= ST_IDLE;
    end
  end

`ifdef UARTARB_LINELOCK_EN
  localparam int unsigned TMO_W = clog2(LOCK_TMO) + 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Lock on any non-newline grant; release on newline or after LOCK_TMO idle cycles.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      locked  <= 1'b0;
      tmo_cnt <= '0;
    end else if (load) begin
      locked  <= (fifo_dout[grant_idx] != UART_NL);
      tmo_cnt <= '0;
    end else if (!locked || !fifo_empty[owner] || push[owner]) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt == TMO_W'(LOCK_TMO - 1)) begin
      locked  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  assign TX_VALID = (state == ST_GRANT);
  assign TX_DATA  = tx_data;
  assign OWNER    = owner;
  assign LOCKED   = locked;

endmodule

// File: tb/tb_darkuart_txarb.sv
// Directed bench for darkuart_txarb (NREQ=2, DEPTH=4, LOCK_TMO=16). Expected
// values for the lock scenarios follow UARTARB_LINELOCK_EN when defined.
module tb_darkuart_txarb;
  import darkuart_pkg::*;

`ifdef UARTARB_LINELOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [0:0]  owner;
  logic        locked;

  int    n_cmp = 0;
  int    n_bad = 0;
  byte_t got [$];
  byte_t exp_lock [6];

  darkuart_txarb #(.NREQ(2), .DEPTH(4), .LOCK_TMO(16)) dut (
    .CLK       (clk),
    .RES_N     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_READY (req_ready),
    .TX_VALID  (tx_valid),
    .TX_DATA   (tx_data),
    .TX_READY  (tx_ready),
    .OWNER     (owner),
    .LOCKED    (locked)
  );

  always #5 clk = ~clk;

  // Bytes accepted by the UART: valid & ready seen mid-cycle are taken at the next edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) got.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_data  = {d1, d0};
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    tx_ready  = 1'b0;
    drive(2'b00, 8'h00, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    got.delete();
  endtask

  initial begin
`ifdef UARTARB_LINELOCK_EN
    exp_lock = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
`else
    exp_lock = '{8'h41, 8'h43, 8'h42, 8'h44, 8'h0A, 8'h0A};
`endif

    // Reset state
    pulse_reset();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_req_ready", req_ready, 2'b11);
    check("rst_owner", owner, 1);
    check("rst_locked", locked, 0);

    // Single requester: two-cycle latency
    tx_ready = 1'b1;
    drive(2'b01, 8'h41, 8'h00);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    check("single_lat1_valid", tx_valid, 0);
    tick();
    check("single_valid", tx_valid, 1);
    check("single_data", tx_data, 8'h41);
    check("single_owner", owner, 0);

    // Round-robin with both requesters streaming
    pulse_reset();
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 8'h41, 8'h42);
      tick();
    end
    drive(2'b00, 8'h00, 8'h00);
    repeat (10) tick();
    check("rr_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_byte%0d", i), got[i], (i % 2 == 0) ? 8'h41 : 8'h42);

    // Backpressure: 4 in FIFO plus 1 in output register, then ready drops
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp_ready%0d", k), req_ready[0], (k < 5) ? 1 : 0);
      drive(2'b01, 8'(8'h10 + k), 8'h00);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold_valid%0d", k), tx_valid, 1);
      check($sformatf("bp_hold_data%0d", k), tx_data, 8'h10);
      check($sformatf("bp_hold_ready%0d", k), req_ready[0], 0);
      tick();
    end
    drive(2'b00, 8'h00, 8'h00);
    got.delete();
    tx_ready = 1'b1;
    repeat (7) tick();
    check("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bp_byte%0d", i), got[i], 8'(8'h10 + i));

    // Line lock: "AB\n" and "CD\n" offered together
    pulse_reset();
    tx_ready = 1'b1;
    drive(2'b11, 8'h41, 8'h43);
    tick();
    drive(2'b11, 8'h42, 8'h44);
    tick();
    check("lock_after_first", locked, LOCK_ON);
    drive(2'b11, 8'h0A, 8'h0A);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    tick();
    check("lock_after_nl", locked, 0);
    tick();
    check("lock_second_line", locked, LOCK_ON);
    repeat (4) tick();
    check("lock_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("lock_byte%0d", i), got[i], exp_lock[i]);
    check("lock_end", locked, 0);

    // Lock timeout: requester 0 sends one byte, requester 1 waits behind the lock
    pulse_reset();
    tx_ready = 1'b1;
    drive(2'b01, 8'h41, 8'h00);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    tick();
    check("tmo_locked", locked, LOCK_ON);
    drive(2'b10, 8'h00, 8'h43);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    repeat (14) tick();
    check("tmo_still_locked", locked, LOCK_ON);
    check("tmo_wait_valid", tx_valid, 0);
    check("tmo_wait_count", got.size(), LOCK_ON ? 1 : 2);
    tick();
    check("tmo_released", locked, 0);
    check("tmo_release_valid", tx_valid, 0);
    tick();
    check("tmo_grant_valid", tx_valid, LOCK_ON);
    check("tmo_grant_data", tx_data, 8'h43);
    check("tmo_grant_owner", owner, 1);
    tick();
    check("tmo_final_count", got.size(), 2);
    check("tmo_final_byte", got[1], 8'h43);

    // Asynchronous reset mid-stream discards everything
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 8'(8'h55 + 8'h11 * k), 8'h00);
      tick();
    end
    drive(2'b00, 8'h00, 8'h00);
    check("mid_pre_valid", tx_valid, 1);
    check("mid_pre_owner", owner, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_owner", owner, 1);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_ready", req_ready, 2'b11);
    tick();
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    got.delete();
    repeat (5) tick();
    check("mid_post_valid", tx_valid, 0);
    check("mid_post_count", got.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
